// File: rtl/uart_rx_packer.sv
// Oversampled 8N1 UART receiver that packs bytes LSB-first into 32-bit words.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_packer #(
    parameter int OVERSAMPLE = 16,
    parameter int IDLE_BITS  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] prescaler,
    input  logic        rx_i,
    output logic [31:0] data_o,
    output logic [2:0]  width_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        parity_err_o
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);
    localparam int IDLE_TICKS = IDLE_BITS * OVERSAMPLE;
    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TICKS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BREAK = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PAR   = 3'd3;
`endif

    logic          r_rx_meta, r_rxs, r_rxs_d;
    logic [31:0]   r_presc, r_tick_cnt;
    logic [2:0]    r_state;
    logic [SW-1:0] r_sub;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par_bad;
    logic [IW-1:0] r_idle;
    logic          r_idle_run;
    logic [31:0]   r_pack;
    logic [2:0]    r_cnt;
    logic [31:0]   r_data;
    logic [2:0]    r_width;
    logic          r_valid;
    logic          r_ferr, r_ovr;

    logic w_tick, w_fall, w_sample, w_stop_smp;
    logic w_accept, w_timeout, w_want_move, w_move, w_hold_free;

    assign w_tick      = (r_tick_cnt == r_presc);
    assign w_fall      = r_rxs_d && !r_rxs;
    assign w_sample    = w_tick &&
                         (r_sub == ((r_state == S_START) ? HALF_M1 : FULL_M1));
    assign w_stop_smp  = w_sample && (r_state == S_STOP);
    assign w_accept    = w_stop_smp && r_rxs && !r_par_bad;
    assign w_timeout   = r_idle_run && (r_idle == IDLE_MAX);
    assign w_want_move = (r_cnt == 3'd4) || (w_timeout && (r_cnt != 3'd0));
    assign w_hold_free = !r_valid || ready_i;
    assign w_move      = w_want_move && w_hold_free;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_d    <= 1'b1;
            r_tick_cnt <= '0;
            r_presc    <= prescaler;
        end else begin
            r_rx_meta <= rx_i;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
            // New divider is latched only on wrap so a running count never overshoots it
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_presc    <= prescaler;
            end else begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_sub     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if (w_tick)
                r_sub <= w_sample ? '0 : r_sub + 1'b1;
            case (r_state)
                S_IDLE: if (w_fall) begin
                    r_state   <= S_START;
                    r_sub     <= '0;
                    r_par_bad <= 1'b0;
                end
                S_START: if (w_sample) begin
                    r_state <= r_rxs ? S_IDLE : S_DATA;
                    r_bit   <= '0;
                end
                S_DATA: if (w_sample) begin
                    r_shift <= {r_rxs, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit == 3'd7) r_state <= S_PAR;
                end
                S_PAR: if (w_sample) begin
                    r_par_bad <= r_rxs ^ (^r_shift);
                    r_state   <= S_STOP;
`else
                    if (r_bit == 3'd7) r_state <= S_STOP;
`endif
                end
                S_STOP: if (w_sample)
                    r_state <= r_rxs ? S_IDLE : S_BREAK;
                S_BREAK: if (r_rxs)
                    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idle     <= '0;
            r_idle_run <= 1'b0;
        end else if (r_state == S_IDLE && w_fall) begin
            r_idle     <= '0;
            r_idle_run <= 1'b0;
        end else if (w_stop_smp) begin
            r_idle     <= '0;
            r_idle_run <= 1'b1;
        end else if (w_tick && r_idle_run && r_idle != IDLE_MAX) begin
            r_idle <= r_idle + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pack  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_width <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_smp && !r_rxs;
            r_ovr  <= w_accept && (r_cnt == 3'd4) && !w_move;
            // A byte landing on a move cycle starts the next word in lane 0
            if (w_accept) begin
                if (w_move) begin
                    r_pack <= {24'd0, r_shift};
                    r_cnt  <= 3'd1;
                end else if (r_cnt != 3'd4) begin
                    r_pack[{r_cnt[1:0], 3'b000} +: 8] <= r_shift;
                    r_cnt <= r_cnt + 3'd1;
                end
            end else if (w_move) begin
                r_pack <= '0;
                r_cnt  <= '0;
            end
            if (w_move) begin
                r_data  <= r_pack;
                r_width <= r_cnt;
                r_valid <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    always_ff @(posedge clk_i) begin
        if (reset_i) r_perr <= 1'b0;
        else         r_perr <= w_stop_smp && r_rxs && r_par_bad;
    end
    assign parity_err_o = r_perr;
`else
    assign parity_err_o = 1'b0;
`endif

    assign data_o      = r_data;
    assign width_o     = r_width;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer at prescaler=0 (16 clk per bit).
// Honours UART_RX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_rx_packer;
    logic        clk_i = 1'b0;
    logic        reset_i, rx_i, ready_i;
    logic [31:0] prescaler;
    logic [31:0] data_o;
    logic [2:0]  width_o;
    logic        valid_o, frame_err_o, overrun_o, parity_err_o;

`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // stop sample = 2 sync + 1 edge + 8 half-bit + 16 per later bit
    localparam int STOP_AT  = 11 + 16 * NB;
    localparam int FLUSH_AT = STOP_AT + 160 + 1;
    localparam int FRAME    = 16 * (NB + 1);

    uart_rx_packer dut (
        .clk_i(clk_i), .reset_i(reset_i), .prescaler(prescaler),
        .rx_i(rx_i), .data_o(data_o), .width_o(width_o),
        .valid_o(valid_o), .ready_i(ready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0;
    logic [31:0] wq[$];
    logic [31:0] wwq[$];

    always @(negedge clk_i) begin
        #2;
        if (valid_o && ready_i) begin
            wq.push_back(data_o);
            wwq.push_back({29'd0, width_o});
        end
        if (frame_err_o)  n_ferr++;
        if (overrun_o)    n_ovr++;
        if (parity_err_o) n_perr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input logic pflip);
        line(1'b0, 16);
        for (int i = 0; i < 8; i++) line(b[i], 16);
`ifdef UART_RX_PARITY_EN
        line((^b) ^ pflip, 16);
`endif
        line(stop, 16);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!valid_o && k < 600) begin
            @(negedge clk_i);
            k++;
        end
    endtask

    int unsigned c0;
    int k, b, f, o, p;

    initial begin
        rx_i = 1'b1;
        ready_i = 1'b1;
        prescaler = 32'd0;
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_data", data_o, 32'h0);
        check("rst_width", {29'd0, width_o}, 32'd0);
        check("rst_flags", {28'd0, valid_o, frame_err_o, overrun_o,
                            parity_err_o}, 32'd0);
        reset_i = 1'b0;
        line(1'b1, 5);

        // four bytes -> one full word
        b = wq.size();
        send(8'hEF, 1'b1, 1'b0);
        send(8'hBE, 1'b1, 1'b0);
        send(8'hAD, 1'b1, 1'b0);
        send(8'hDE, 1'b1, 1'b0);
        line(1'b1, 40);
        check("w4_count", wq.size() - b, 32'd1);
        if (wq.size() > b) begin
            check("w4_data", wq[b], 32'hDEADBEEF);
            check("w4_width", wwq[b], 32'd4);
        end

        // single byte flushed exactly at idle timeout
        c0 = cyc;
        send(8'h42, 1'b1, 1'b0);
        wait_valid(k);
        check("flush_time", cyc - c0, FLUSH_AT);
        check("flush_data", data_o, 32'h00000042);
        check("flush_width", {29'd0, width_o}, 32'd1);
        line(1'b1, 5);

        // bad stop bit followed by a held-low line
        b = wq.size();
        f = n_ferr;
        send(8'h55, 1'b0, 1'b0);
        line(1'b0, 3 * FRAME);
        line(1'b1, 200);
        check("ferr_pulses", n_ferr - f, 32'd1);
        check("ferr_noword", wq.size() - b, 32'd0);

        // consumer stalled: holding reg + packer full, rest overrun
        ready_i = 1'b0;
        o = n_ovr;
        for (int i = 1; i <= 12; i++) begin
            send(8'(i), 1'b1, 1'b0);
            if (i == 8)
                check("stall_mid", data_o, 32'h04030201);
        end
        check("stall_data", data_o, 32'h04030201);
        check("stall_width", {29'd0, width_o}, 32'd4);
        check("stall_valid", {31'd0, valid_o}, 32'd1);
        check("overruns", n_ovr - o, 32'd4);
        b = wq.size();
        ready_i = 1'b1;
        line(1'b1, 10);
        check("drain_count", wq.size() - b, 32'd2);
        if (wq.size() >= b + 2) begin
            check("drain_w1", wq[b], 32'h04030201);
            check("drain_w2", wq[b+1], 32'h08070605);
        end
        line(1'b1, 200);

        // one-clock glitch while idle
        b = wq.size();
        f = n_ferr;
        line(1'b0, 1);
        line(1'b1, 200);
        check("glitch_ferr", n_ferr - f, 32'd0);
        check("glitch_noword", wq.size() - b, 32'd0);

        // reset mid-byte drops partial word and frame
        send(8'h11, 1'b1, 1'b0);
        line(1'b0, 16);
        line(1'b1, 16);
        line(1'b0, 16);
        reset_i = 1'b1;
        rx_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        line(1'b1, 20);
        check("rst_mid_valid", {31'd0, valid_o}, 32'd0);
        b = wq.size();
        send(8'hA5, 1'b1, 1'b0);
        wait_valid(k);
        check("post_rst_data", data_o, 32'h000000A5);
        check("post_rst_width", {29'd0, width_o}, 32'd1);
        line(1'b1, 5);
        check("post_rst_count", wq.size() - b, 32'd1);

`ifdef UART_RX_PARITY_EN
        p = n_perr;
        send(8'h01, 1'b1, 1'b1);
        line(1'b1, 20);
        check("par_bad_pulse", n_perr - p, 32'd1);
        send(8'h01, 1'b1, 1'b0);
        wait_valid(k);
        check("par_ok_data", data_o, 32'h00000001);
        check("par_ok_width", {29'd0, width_o}, 32'd1);
        check("par_ok_pulse", n_perr - p, 32'd1);
`else
        p = 0;
        check("par_tied", n_perr - p, 32'd0);
`endif
        line(1'b1, 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
